// File: rtl/lsu_top.sv
// lsu_top: load/store unit, one outstanding req/gnt/rvalid transaction, single-cycle pass-through for ALU results.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of silently aligning them down.
module lsu_top #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_out_vld_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] alu_rs2_data_i,
  input  logic [4:0]  alu_rd_i,
  input  logic        alu_rd_wen_i,
  input  logic [3:0]  alu_ls_i,
  input  logic        alu_lsign_i,
  output logic        lsu_ready_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        lsu_wb_vld_o,
  output logic [4:0]  lsu_wb_rd_o,
  output logic        lsu_wb_wen_o,
  output logic [31:0] lsu_wb_data_o,
  output logic        lsu_err_o,
  output logic        lsu_misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e state_q, state_d;
  logic        req_q, req_d, we_q, we_d, wb_vld_q, wb_vld_d, wb_wen_q, wb_wen_d;
  logic        err_q, err_d, mis_q, mis_d, rd_wen_q, rd_wen_d, sign_q, sign_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  wb_rd_q, wb_rd_d, rd_q, rd_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  op, sz, off;
  logic        is_mem, trap;
  logic [3:0]  be;
  logic [31:0] wdata, lane, ld;
  assign op     = alu_ls_i[3:2];
  assign sz     = alu_ls_i[1:0];
  assign is_mem = (op == 2'b01 || op == 2'b10) && sz != 2'b11;
  // offset is aligned down per size so misaligned accesses degrade to the containing lane
  assign off    = sz == 2'b00 ? alu_out_i[1:0] : sz == 2'b01 ? {alu_out_i[1], 1'b0} : 2'b00;
  assign be     = (sz == 2'b00 ? 4'b0001 : sz == 2'b01 ? 4'b0011 : 4'b1111) << off;
  assign wdata  = sz == 2'b00 ? {4{alu_rs2_data_i[7:0]}} : sz == 2'b01 ? {2{alu_rs2_data_i[15:0]}} : alu_rs2_data_i;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap   = (sz == 2'b01 && alu_out_i[0]) || (sz == 2'b10 && alu_out_i[1:0] != 2'b00);
`else
  assign trap   = 1'b0;
`endif
  assign lane   = dmem_rdata_i >> {off_q, 3'b000};
  assign ld     = size_q == 2'b00 ? {{24{sign_q & lane[7]}}, lane[7:0]} :
                  size_q == 2'b01 ? {{16{sign_q & lane[15]}}, lane[15:0]} : lane;
  always_comb begin
    state_d = state_q; req_d = req_q; we_d = we_q; addr_d = addr_q; wdata_d = wdata_q; be_d = be_q;
    wb_vld_d = 1'b0; wb_rd_d = wb_rd_q; wb_wen_d = wb_wen_q; wb_data_d = wb_data_q;
    err_d = 1'b0; mis_d = 1'b0; cnt_d = cnt_q;
    rd_d = rd_q; rd_wen_d = rd_wen_q; size_d = size_q; sign_d = sign_q; off_d = off_q;
    case (state_q)
      IDLE: if (alu_out_vld_i) begin
        wb_rd_d = alu_rd_i;
        if (!is_mem || trap) begin
          wb_vld_d = 1'b1; wb_wen_d = !is_mem && alu_rd_wen_i; wb_data_d = is_mem ? 32'd0 : alu_out_i; mis_d = is_mem;
        end else begin
          wb_rd_d = wb_rd_q; state_d = REQ; req_d = 1'b1; we_d = op[1];
          addr_d = {alu_out_i[31:2], 2'b00}; be_d = be; wdata_d = wdata;
          rd_d = alu_rd_i; rd_wen_d = alu_rd_wen_i; size_d = sz; sign_d = alu_lsign_i; off_d = off;
        end
      end
      REQ: if (dmem_gnt_i) begin
        req_d = 1'b0; cnt_d = 8'd0; state_d = we_q ? IDLE : WAIT;
        if (we_q) begin
          wb_vld_d = 1'b1; wb_rd_d = rd_q; wb_wen_d = 1'b0; wb_data_d = 32'd0;
        end
      end
      WAIT: if (dmem_rvalid_i || cnt_q == 8'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE; wb_vld_d = 1'b1; wb_rd_d = rd_q; err_d = !dmem_rvalid_i;
        wb_wen_d = dmem_rvalid_i && rd_wen_q; wb_data_d = dmem_rvalid_i ? ld : 32'd0;
      end else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE; req_q <= 1'b0; we_q <= 1'b0; addr_q <= '0; wdata_q <= '0; be_q <= '0;
      wb_vld_q <= 1'b0; wb_rd_q <= '0; wb_wen_q <= 1'b0; wb_data_q <= '0; err_q <= 1'b0; mis_q <= 1'b0;
      cnt_q <= '0; rd_q <= '0; rd_wen_q <= 1'b0; size_q <= '0; sign_q <= 1'b0; off_q <= '0;
    end else begin
      state_q <= state_d; req_q <= req_d; we_q <= we_d; addr_q <= addr_d; wdata_q <= wdata_d; be_q <= be_d;
      wb_vld_q <= wb_vld_d; wb_rd_q <= wb_rd_d; wb_wen_q <= wb_wen_d; wb_data_q <= wb_data_d;
      err_q <= err_d; mis_q <= mis_d; cnt_q <= cnt_d;
      rd_q <= rd_d; rd_wen_q <= rd_wen_d; size_q <= size_d; sign_q <= sign_d; off_q <= off_d;
    end
  end
  assign lsu_ready_o    = state_q == IDLE;
  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
  assign dmem_be_o      = be_q;
  assign lsu_wb_vld_o   = wb_vld_q;
  assign lsu_wb_rd_o    = wb_rd_q;
  assign lsu_wb_wen_o   = wb_wen_q;
  assign lsu_wb_data_o  = wb_data_q;
  assign lsu_err_o      = err_q;
  assign lsu_misalign_o = mis_q;
endmodule

// File: doc/lsu_top.md
# lsu_top

Load/store unit of the five-stage core, sitting directly downstream of the ALU/execute stage and upstream of register writeback. Accepts the registered execute result (address or ALU value, store data, load/store control, destination register), runs a single outstanding request/grant/response transaction on the data-memory port for loads and stores, and back-pressures execute with `lsu_ready`. Non-memory results pass through with one cycle of latency.

## Interface
- `TIMEOUT_CYC`, 255: cycles in WAIT without `dmem_rvalid` before the load is abandoned (1..255).
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  asynchronous reset, active-high.
- `alu_out_vld`  in  1  execute slot valid.
- `alu_out`  in  32  ALU result; byte address for memory ops.
- `alu_rs2_data`  in  32  store data.
- `alu_rd`  in  5  destination register.
- `alu_rd_wen`  in  1  destination write enable.
- `alu_LS`  in  4  [3:2] op: 00 none, 01 load, 10 store, 11 none; [1:0] size: 00 byte, 01 half, 10 word, 11 none.
- `alu_lsign`  in  1  load extension: 1 sign, 0 zero.
- `lsu_ready`  out  1  stage can accept; execute freezes when low.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 store, 0 load.
- `dmem_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  32  load data word.
- `lsu_wb_vld`  out  1  writeback slot valid (one-cycle pulse per instruction).
- `lsu_wb_rd`  out  5  writeback register.
- `lsu_wb_wen`  out  1  writeback enable.
- `lsu_wb_data`  out  32  writeback data.
- `lsu_err`  out  1  one-cycle pulse: load response timeout.
- `lsu_misalign`  out  1  one-cycle pulse: misaligned access (see Configuration).

## Operation
- FSM: IDLE, REQ, WAIT. `lsu_ready` = (state == IDLE), combinational from state only.
- IDLE, accept = `alu_out_vld & lsu_ready`:
  - non-memory op (op/size 11 treated as none): `lsu_wb_*` <= {rd, rd_wen, alu_out}, `lsu_wb_vld`<=1; stay IDLE.
  - load/store: capture rd, rd_wen, size, lsign, addr[1:0]; drive `dmem_req`=1, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` (registered); go REQ.
- REQ: hold all `dmem_*` stable until `dmem_gnt`. On gnt: `dmem_req`<=0; store -> `lsu_wb_vld`<=1, `lsu_wb_wen`<=0, data 0, go IDLE; load -> clear timeout counter, go WAIT.
- WAIT: on `dmem_rvalid`: lane = rdata >> (8*addr[1:0]); byte/half extended per `lsign`; word unchanged; `lsu_wb_*` <= {rd, rd_wen, result}, vld 1; go IDLE. Else counter+1; at counter == `TIMEOUT_CYC`: `lsu_err`<=1, wb vld 1, wen 0, data 0, go IDLE.
- Store lanes: SB wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, be=4'b0011<<{addr[1],1'b0}; SW wdata=rs2, be=4'b1111. Loads drive be per size likewise.
- `dmem_rvalid` outside WAIT (e.g. late after timeout) ignored. `dmem_gnt` outside REQ ignored.
- `lsu_wb_vld`, `lsu_err`, `lsu_misalign` are single-cycle pulses; wb rd/wen/data hold until next update.

## Timing
- Reset: state IDLE; `dmem_req`,`dmem_we`,`dmem_be`,`dmem_addr`,`dmem_wdata`, all `lsu_wb_*`, `lsu_err`, `lsu_misalign`, counter = 0; `lsu_ready`=1 (follows IDLE). Reset mid-transaction drops `dmem_req` immediately; nothing is written back.
- Accept at edge N: non-memory wb_vld at N+1; `dmem_req` high from N+1.
- Store, gnt in first REQ cycle: wb_vld at N+2, `lsu_ready` high at N+2.
- Load, gnt at N+1, rvalid at N+2: wb_vld at N+3; `lsu_ready` high at N+3.
- `dmem_gnt` and `dmem_rvalid` same cycle not supported; rvalid earliest one cycle after gnt.
- Back-to-back non-memory ops: one per cycle, no bubbles.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no memory request; at N+1 `lsu_misalign`=1, wb vld 1, wen 0, data 0; stays IDLE.
- Undefined: `lsu_misalign` tied 0; misaligned access silently aligned down (half uses addr[1] only, word ignores addr[1:0]) and proceeds normally.

## Test plan
- ALU op rd=5, wen=1, alu_out=0x1234 -> next cycle wb_vld=1, rd=5, data=0x0000_1234; `lsu_ready` never drops.
- SB addr=0x103, rs2=0xAABBCCDD, gnt 2 cycles late -> dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD held stable, wb wen=0 one cycle after gnt.
- LB addr=0x101 lsign=1, rdata=0x0000_8000 -> wb data 0xFFFF_FF80; same with lsign=0 -> 0x0000_0080; LHU addr=0x102 rdata=0xBEEF0000 -> 0x0000_BEEF.
- Load, never rvalid, TIMEOUT_CYC=4 -> `lsu_err` pulse 4 cycles into WAIT, wb wen=0, IDLE; late rvalid then ignored.
- LW addr=0x102 -> with macro: no dmem_req, `lsu_misalign` pulse; without: dmem_addr=0x100, be=1111.
- Assert RST while in WAIT -> `dmem_req`, wb outputs 0 immediately, `lsu_ready`=1; subsequent rvalid ignored.
